// File: rtl/result_uart_tx.sv
// result_uart_tx: captures a 16-bit product on a valid/ready handshake and
// sends it as two UART frames (low byte first) on a single serial pin.
// Optional feature macro: RESULT_UART_TX_PARITY_EN adds an even-parity bit
// after the eight data bits of each frame (8E1 instead of 8N1).
module result_uart_tx #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] res_data,
    input  logic        res_valid,
    output logic        res_ready,
    output logic        tx,
    output logic        busy,
    output logic        overrun
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef RESULT_UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;

    localparam logic [7:0] LAST_CNT = 8'(CLKS_PER_BIT - 1);

    logic [2:0]  state;
    logic [15:0] shadow;
    logic [7:0]  shifter;
    logic [2:0]  bit_idx;
    logic        byte_sel;
    logic [7:0]  baud_cnt;
    logic [7:0]  cur_byte;
    logic        accept;
    logic        bit_end;

    assign accept  = res_valid & res_ready;
    assign bit_end = (baud_cnt == LAST_CNT);

    // Byte of the captured product belonging to the frame in flight.
    always_comb begin
        cur_byte = byte_sel ? shadow[15:8] : shadow[7:0];
    end

    // Baud counter: free-runs while a transfer is active, parked at 0 in IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            baud_cnt <= 8'd0;
        end else if (state == S_IDLE || bit_end) begin
            baud_cnt <= 8'd0;
        end else begin
            baud_cnt <= baud_cnt + 8'd1;
        end
    end

    // Frame sequencer: each branch registers the line level of the next bit,
    // so tx changes exactly on the edge that ends the previous bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            tx        <= 1'b1;
            res_ready <= 1'b1;
            busy      <= 1'b0;
            shadow    <= 16'd0;
            shifter   <= 8'd0;
            bit_idx   <= 3'd0;
            byte_sel  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        shadow    <= res_data;
                        byte_sel  <= 1'b0;
                        bit_idx   <= 3'd0;
                        tx        <= 1'b0;
                        res_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= S_START;
                    end
                end
                S_START: begin
                    // Shifter is (re)loaded from the shadow copy here, so a
                    // later change on res_data can never reach the line.
                    if (bit_end) begin
                        shifter <= cur_byte;
                        tx      <= cur_byte[0];
                        bit_idx <= 3'd0;
                        state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        if (bit_idx == 3'd7) begin
`ifdef RESULT_UART_TX_PARITY_EN
                            tx    <= ^cur_byte;
                            state <= S_PARITY;
`else
                            tx    <= 1'b1;
                            state <= S_STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shifter <= {1'b0, shifter[7:1]};
                            tx      <= shifter[1];
                        end
                    end
                end
`ifdef RESULT_UART_TX_PARITY_EN
                S_PARITY: begin
                    if (bit_end) begin
                        tx    <= 1'b1;
                        state <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (bit_end) begin
                        if (!byte_sel) begin
                            // Second frame follows with no idle gap.
                            byte_sel <= 1'b1;
                            tx       <= 1'b0;
                            state    <= S_START;
                        end else begin
                            tx        <= 1'b1;
                            res_ready <= 1'b1;
                            busy      <= 1'b0;
                            state     <= S_IDLE;
                        end
                    end
                end
                default: begin
                    tx        <= 1'b1;
                    res_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

    // Sticky overrun: a product offered while busy is dropped and flagged;
    // the next successful accept clears the flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (accept) begin
            overrun <= 1'b0;
        end else if (res_valid && state != S_IDLE) begin
            overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_result_uart_tx.sv
// Bench for result_uart_tx: three instances (C=4, C=1, C=2) checked every
// cycle against a bit-position model, plus literal frame sequences.
module tb_result_uart_tx;

`ifdef RESULT_UART_TX_PARITY_EN
    localparam int FB = 11;
    localparam bit PAR = 1'b1;
`else
    localparam int FB = 10;
    localparam bit PAR = 1'b0;
`endif

    logic        clk;
    logic        rst [3];
    logic        vld [3];
    logic [15:0] dat [3];
    logic        txo [3];
    logic        rdy [3];
    logic        bsy [3];
    logic        ovr [3];

    int checks;
    int failures;
    bit chk_en;

    // expected-state model
    logic        m_busy [3];
    int          m_t    [3];
    logic [15:0] m_d    [3];
    logic        m_ovr  [3];

    result_uart_tx #(.CLKS_PER_BIT(4)) u_c4 (
        .clk(clk), .reset(rst[0]), .res_data(dat[0]), .res_valid(vld[0]),
        .res_ready(rdy[0]), .tx(txo[0]), .busy(bsy[0]), .overrun(ovr[0]));
    result_uart_tx #(.CLKS_PER_BIT(1)) u_c1 (
        .clk(clk), .reset(rst[1]), .res_data(dat[1]), .res_valid(vld[1]),
        .res_ready(rdy[1]), .tx(txo[1]), .busy(bsy[1]), .overrun(ovr[1]));
    result_uart_tx #(.CLKS_PER_BIT(2)) u_c2 (
        .clk(clk), .reset(rst[2]), .res_data(dat[2]), .res_valid(vld[2]),
        .res_ready(rdy[2]), .tx(txo[2]), .busy(bsy[2]), .overrun(ovr[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int cval(input int i);
        return (i == 0) ? 4 : ((i == 1) ? 1 : 2);
    endfunction

    // Line level t edges after the accept edge, from frame arithmetic.
    function automatic logic exp_bit(input logic [15:0] d, input int t, input int c);
        int bp, b;
        logic [7:0] by;
        bp = t / c;
        b  = bp % FB;
        by = ((bp / FB) == 0) ? d[7:0] : d[15:8];
        if (b == 0) return 1'b0;
        if (b <= 8) return by[b-1];
        if (PAR && b == 9) return ^by;
        return 1'b1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            m_busy[i] = 1'b0; m_t[i] = 0; m_d[i] = 16'd0; m_ovr[i] = 1'b0;
        end
    end

    // Model update on each rising edge, from pre-edge inputs.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst[i]) begin
                m_busy[i] = 1'b0; m_ovr[i] = 1'b0; m_t[i] = 0;
            end else if (!m_busy[i]) begin
                if (vld[i]) begin
                    m_busy[i] = 1'b1; m_t[i] = 0; m_d[i] = dat[i]; m_ovr[i] = 1'b0;
                end
            end else begin
                if (vld[i]) m_ovr[i] = 1'b1;
                m_t[i]++;
                if (m_t[i] == 2 * FB * cval(i)) m_busy[i] = 1'b0;
            end
        end
    end

    // Per-cycle comparison on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("tx%0d", i), txo[i],
                    m_busy[i] ? exp_bit(m_d[i], m_t[i], cval(i)) : 1'b1);
                chk($sformatf("ready%0d", i), rdy[i], !m_busy[i]);
                chk($sformatf("busy%0d", i), bsy[i], m_busy[i]);
                chk($sformatf("overrun%0d", i), ovr[i], m_ovr[i]);
            end
        end
    end

    task automatic send(input int i, input logic [15:0] d, input logic [15:0] d_after);
        @(posedge clk); #2;
        vld[i] = 1'b1; dat[i] = d;
        @(posedge clk); #2;
        vld[i] = 1'b0; dat[i] = d_after;
    endtask

    // Sends one product and samples the middle of every bit.
    task automatic xfer(input int i, input logic [15:0] d, input logic [15:0] d_after,
                        output logic [31:0] seq, output int lo);
        int c;
        c = cval(i);
        seq = 32'd0;
        lo = 0;
        send(i, d, d_after);
        @(negedge clk);
        for (int j = 0; j < 2 * FB; j++) begin
            seq = {seq[30:0], txo[i]};
            for (int k = 0; k < c; k++) begin
                if (!rdy[i]) lo++;
                @(negedge clk);
            end
        end
    endtask

    task automatic wait_idle(input int i);
        int n;
        n = 0;
        while (!rdy[i] && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("idle_wait%0d", i), rdy[i], 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] seq;
        int lo;
        checks = 0;
        failures = 0;
        chk_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1; vld[i] = 1'b1; dat[i] = 16'h1111;
        end

        // reset held with valid high
        repeat (3) begin
            @(posedge clk); #2;
            chk_en = 1'b1;
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                chk("rst_tx", txo[i], 1'b1);
                chk("rst_ready", rdy[i], 1'b1);
                chk("rst_busy", bsy[i], 1'b0);
                chk("rst_overrun", ovr[i], 1'b0);
            end
        end
        @(posedge clk); #2;
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b0; vld[i] = 1'b0;
        end
        @(negedge clk);
        for (int i = 0; i < 3; i++) chk("rst_no_frame", bsy[i], 1'b0);

        // C=4, 0xA55A
        xfer(0, 16'hA55A, 16'hA55A, seq, lo);
`ifdef RESULT_UART_TX_PARITY_EN
        chk("a55a_seq", seq, 32'b0_01011010_0_1_0_10100101_0_1);
        chk("a55a_ready_lo", lo, 88);
`else
        chk("a55a_seq", seq, 32'b0_01011010_1_0_10100101_1);
        chk("a55a_ready_lo", lo, 80);
`endif
        chk("a55a_ready_back", rdy[0], 1'b1);

        // C=1, 0x0000 then data changes to 0xFFFF after accept
        xfer(1, 16'h0000, 16'hFFFF, seq, lo);
`ifdef RESULT_UART_TX_PARITY_EN
        chk("zero_seq", seq, 32'b0_00000000_0_1_0_00000000_0_1);
`else
        chk("zero_seq", seq, 32'b0_00000000_1_0_00000000_1);
`endif
        chk("zero_ready_lo", lo, 2 * FB);

        // C=2 overrun during a transfer of 0x1234
        send(2, 16'h1234, 16'h1234);
        repeat (8) @(posedge clk);
        #2 vld[2] = 1'b1;
        @(posedge clk); #2 vld[2] = 1'b0;
        @(negedge clk);
        chk("ovr_set", ovr[2], 1'b1);
        chk("ovr_still_busy", bsy[2], 1'b1);
        wait_idle(2);
        chk("ovr_sticky", ovr[2], 1'b1);
        send(2, 16'h00AA, 16'h00AA);
        @(negedge clk);
        chk("ovr_cleared", ovr[2], 1'b0);
        wait_idle(2);

        // C=4 reset during high-byte data bit 3, then 0x00FF
        send(0, 16'hC3C3, 16'hC3C3);
        repeat ((FB + 4) * 4) @(posedge clk);
        #2 rst[0] = 1'b1;
        @(posedge clk); #2 rst[0] = 1'b0;
        @(negedge clk);
        chk("midrst_tx", txo[0], 1'b1);
        chk("midrst_ready", rdy[0], 1'b1);
        chk("midrst_busy", bsy[0], 1'b0);
        xfer(0, 16'h00FF, 16'h00FF, seq, lo);
`ifdef RESULT_UART_TX_PARITY_EN
        chk("ff_seq", seq, 32'b0_11111111_0_1_0_00000000_0_1);
`else
        chk("ff_seq", seq, 32'b0_11111111_1_0_00000000_1);
`endif

        // C=2, 0x0701
        xfer(2, 16'h0701, 16'h0701, seq, lo);
`ifdef RESULT_UART_TX_PARITY_EN
        chk("p0701_seq", seq, 32'b0_10000000_1_1_0_11100000_1_1);
        chk("p0701_ready_lo", lo, 44);
`else
        chk("p0701_seq", seq, 32'b0_10000000_1_0_11100000_1);
        chk("p0701_ready_lo", lo, 40);
`endif
        chk("p0701_ready_back", rdy[2], 1'b1);

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/result_uart_tx.md
# result_uart_tx

Serial transmitter stage that sits directly downstream of the nibble-loaded 8×8 multiplier and consumes its 16-bit product. On a valid/ready handshake it captures the product and sends it as two 8N1 UART frames, low byte first, on a single output pin. This frees the parallel output byte and removes the need for the byte-select pin. Bit rate is derived from the system clock by an internal baud counter.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 8: clock cycles per UART bit; legal range 1–255.

Ports:
- `clk` in 1: system clock; all logic on rising edge; one clock domain only.
- `reset` in 1: synchronous, active-high reset.
- `res_data` in 16: product from the multiplier stage; sampled only on the accept edge.
- `res_valid` in 1: product available; a level or a one-cycle pulse.
- `res_ready` out 1: high only in IDLE; accept = `res_valid & res_ready` at a rising edge.
- `tx` out 1: UART line; idles high.
- `busy` out 1: high while a two-byte transfer is in progress (`busy == ~res_ready`).
- `overrun` out 1: sticky flag; set when `res_valid` is high while `res_ready` is low.

## Operation
- States: IDLE, START, DATA, PARITY (compiled in only with the macro), STOP.
- Internal registers: 16-bit `shadow`, 8-bit shift register, bit index (0–7), byte select (0/1), baud counter (0..CLKS_PER_BIT-1). All outputs are registered.
- IDLE: `tx`=1, `res_ready`=1. On accept, `shadow`←`res_data`, the shift register loads `shadow[7:0]`, byte select←0, baud counter←0, state→START. Changes on `res_data` after the accept edge are ignored.
- The baud counter increments every cycle. When it reaches CLKS_PER_BIT-1 it wraps to 0 and the state machine advances one bit.
- START: `tx`=0 for one bit time, then →DATA.
- DATA: `tx` = shift register LSB. The register shifts right once per bit. After bit 7 →PARITY if compiled in, else →STOP.
- STOP: `tx`=1 for one bit time. At the end of the stop bit:
  - byte select 0: load `shadow[15:8]`, byte select←1, →START. There is no idle gap between the two frames.
  - byte select 1: →IDLE.
- `overrun`:
  - Set on any edge where `res_valid`=1 and the state is not IDLE. The offending product is dropped.
  - Cleared on the next accept edge. Accept has priority: an accept edge clears the flag.
- `reset`=1 at an edge:
  - state←IDLE, `tx`←1, `res_ready`←1, `busy`←0, `overrun`←0; counters and `shadow` ←0.
  - A transfer in progress is aborted mid-bit and not resumed.
  - An accept is not possible on an edge where reset is high.

## Timing
- Let E0 be the accept edge and C = CLKS_PER_BIT.
- Low byte on `tx`:
  - Start bit: E0 through E0+C.
  - Data bit k: E0+(1+k)·C through E0+(2+k)·C.
  - Stop bit: E0+9C through E0+10C.
- High byte: the same pattern offset by 10C. The stop bit ends at E0+20C.
- At edge E0+20C: state IDLE, `res_ready`=1, `busy`=0. The earliest next accept is edge E0+20C+1.
- Total transfer time is 20·C cycles per product, or 22·C with parity.
- C=1 is legal: each bit lasts exactly one cycle.

## Configuration
- `RESULT_UART_TX_PARITY_EN` defined:
  - PARITY state is compiled in. After bit 7, one bit time of even parity (XOR of the 8 data bits) is sent before STOP.
  - Frame is 11 bits; product time is 22·C; `res_ready` returns at E0+22C.
- Not defined:
  - PARITY state and its logic are absent; 8N1 frames of 10 bits; timing as above.

## Test plan
- Reset: hold `reset`=1 for 3 cycles with `res_valid`=1 → `tx`=1, `res_ready`=1, `busy`=0, `overrun`=0 throughout; no frame is started.
- C=4, `res_data`=0xA55A with a one-cycle `res_valid` → `tx` sequence per 4-cycle bit: 0, 0,1,0,1,1,0,1,0, 1, then 0, 1,0,1,0,0,1,0,1, 1. `res_ready` returns exactly 80 cycles after the accept edge.
- C=1, `res_data`=0x0000 → 20-cycle frame pair 0,00000000,1,0,00000000,1. `res_data` is changed to 0xFFFF on the cycle after accept; the transmitted bits are unchanged.
- Overrun: accept 0x1234 with C=2, then pulse `res_valid` at cycle 10 → `overrun`=1 from the next edge and the transfer continues unaffected. The next accept after IDLE clears `overrun` on that edge.
- Reset mid-frame: assert `reset` during data bit 3 of the high byte → `tx`=1 on the next edge, IDLE. A new accept of 0x00FF then sends a full correct two-frame sequence.
- With `RESULT_UART_TX_PARITY_EN`, C=2, `res_data`=0x0701 → low byte parity bit 1, high byte parity bit 1; `res_ready` returns after 44 cycles.
